if_id_stage: RTL

//  Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core. Holds the PC, drives the

---
 rtl/mips_pkg.sv | 23 ++
 rtl/if_id_stage_if.sv | 34 +++
 rtl/if_id_reg.sv | 47 ++++
 rtl/if_id_stage.sv | 91 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Constants shared by the MIPS core: opcodes, bubble encoding, reset PC and
// the fetch stage's next-PC selection.
package mips_pkg;

  localparam int          OP_WIDTH  = 6;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_WIDTH-1:0] OP_J     = 6'h02;
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_WIDTH-1:0] OP_LW    = 6'h23;
  localparam logic [OP_WIDTH-1:0] OP_SW    = 6'h2b;

  typedef enum logic [1:0] {
    PC_SEL_SEQ,
    PC_SEL_HOLD,
    PC_SEL_JUMP,
    PC_SEL_BRANCH
  } pc_sel_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Bus between the fetch/IF-ID stage and its surroundings (hazard unit, ID
// redirect logic, instruction memory, decode). The stage is the slave side.
interface if_id_stage_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
);
  import mips_pkg::*;

  logic                   stall_i;
  logic                   jump_i;
  logic                   branch_taken_i;
  logic [PC_WIDTH-1:0]    jump_target_i;
  logic [PC_WIDTH-1:0]    branch_target_i;
  logic [INSTR_WIDTH-1:0] instr_i;
  logic [PC_WIDTH-1:0]    pc_o;
  logic [PC_WIDTH-1:0]    if_id_pc4_o;
  logic [INSTR_WIDTH-1:0] if_id_instr_o;
  logic                   if_id_valid_o;
  logic [OP_WIDTH-1:0]    op_o;
  logic [CNT_WIDTH-1:0]   stall_cnt_o;
  logic [CNT_WIDTH-1:0]   flush_cnt_o;

  modport master (
    output stall_i, jump_i, branch_taken_i, jump_target_i, branch_target_i, instr_i,
    input  pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, op_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  stall_i, jump_i, branch_taken_i, jump_target_i, branch_target_i, instr_i,
    output pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, op_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, clears to a bubble on flush,
// otherwise captures the freshly fetched instruction and its PC+4.
module if_id_reg #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   hold_i,
  input  logic                   flush_i,
  input  logic [PC_WIDTH-1:0]    pc4_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic [PC_WIDTH-1:0]    pc4_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   valid_o
);
  import mips_pkg::*;

  logic [PC_WIDTH-1:0]    r_pc4;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_valid;

  // NOTE: state is written with <= so every register samples pre-edge values,
  // independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc4   <= '0;
      r_instr <= INSTR_WIDTH'(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (!hold_i) begin
      if (flush_i) begin
        r_pc4   <= '0;
        r_instr <= INSTR_WIDTH'(NOP_INSTR);
        r_valid <= 1'b0;
      end else begin
        r_pc4   <= pc4_i;
        r_instr <= instr_i;
        r_valid <= 1'b1;
      end
    end
  end

  assign pc4_o   = r_pc4;
  assign instr_o = r_instr;
  assign valid_o = r_valid;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage of the 5-stage MIPS core: PC register and next-PC mux with
// stall/redirect priority, IF/ID register, and saturating event counters.
module if_id_stage #(
  parameter int                PC_WIDTH    = 32,
  parameter int                INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter int                CNT_WIDTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  if_id_stage_if.slave bus
);
  import mips_pkg::*;

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

  logic [PC_WIDTH-1:0]    r_pc;
  logic [CNT_WIDTH-1:0]   r_stall_cnt;
  logic [CNT_WIDTH-1:0]   r_flush_cnt;
  pc_sel_e                w_sel;
  logic [PC_WIDTH-1:0]    w_pc4;
  logic [PC_WIDTH-1:0]    w_pc_next;
  logic                   w_hold;
  logic                   w_flush;
  logic [PC_WIDTH-1:0]    w_if_id_pc4;
  logic [INSTR_WIDTH-1:0] w_if_id_instr;
  logic                   w_if_id_valid;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel = PC_SEL_SEQ;
    if (bus.stall_i)             w_sel = PC_SEL_HOLD;
    else if (bus.jump_i)         w_sel = PC_SEL_JUMP;
    else if (bus.branch_taken_i) w_sel = PC_SEL_BRANCH;
  end

  // PC+4 wraps modulo 2^PC_WIDTH; redirect targets are word-aligned here.
  assign w_pc4 = r_pc + PC_STEP;

  always_comb begin
    w_pc_next = w_pc4;
    unique case (w_sel)
      PC_SEL_HOLD:   w_pc_next = r_pc;
      PC_SEL_JUMP:   w_pc_next = bus.jump_target_i & ALIGN_MASK;
      PC_SEL_BRANCH: w_pc_next = bus.branch_target_i & ALIGN_MASK;
      default:       w_pc_next = w_pc4;
    endcase
  end

  assign w_hold  = (w_sel == PC_SEL_HOLD);
  assign w_flush = (w_sel == PC_SEL_JUMP) || (w_sel == PC_SEL_BRANCH);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc        <= RESET_PC_A;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_hold && !(&r_stall_cnt))  r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hold_i  (w_hold),
    .flush_i (w_flush),
    .pc4_i   (w_pc4),
    .instr_i (bus.instr_i),
    .pc4_o   (w_if_id_pc4),
    .instr_o (w_if_id_instr),
    .valid_o (w_if_id_valid)
  );

  assign bus.pc_o          = r_pc;
  assign bus.if_id_pc4_o   = w_if_id_pc4;
  assign bus.if_id_instr_o = w_if_id_instr;
  assign bus.if_id_valid_o = w_if_id_valid;
  assign bus.op_o          = w_if_id_instr[INSTR_WIDTH-1 -: OP_WIDTH];
  assign bus.stall_cnt_o   = r_stall_cnt;
  assign bus.flush_cnt_o   = r_flush_cnt;

endmodule
